// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, ALU/immediate selectors and the I/O memory map.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4;
  localparam logic [2:0] F3_BGE = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4, F3_HU = 3'd5;

  localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
  localparam logic [31:0] DMEM_BASE = 32'h0000_2000;
  localparam logic [31:0] LEDR_BASE = 32'h1000_0000;
  localparam logic [31:0] LEDG_BASE = 32'h1000_1000;
  localparam logic [31:0] HEXL_BASE = 32'h1000_2000;
  localparam logic [31:0] HEXH_BASE = 32'h1000_3000;
  localparam logic [31:0] LCD_BASE  = 32'h1000_4000;
  localparam logic [31:0] SW_BASE   = 32'h1001_0000;
  localparam logic [31:0] BTN_BASE  = 32'h1001_1000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_e;
  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} alu_a_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_e;

  // Immediate from instruction bits [31:7]; opcode bits never contribute.
  function automatic logic [31:0] gen_imm(input imm_e t, input logic [31:7] i);
    case (t)
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  // funct3 plus the alternate bit (instr[30]) picks the ALU operation.
  function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_lsu.sv
// Load/store unit: data memory, memory-mapped I/O registers, byte lanes,
// load extension and address decode.
module rv32i_lsu import rv32i_pkg::*; #(
  parameter int DMEM_WORDS = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [2:0]       funct3,
  input  logic             store,
  input  logic [31:0]      io_sw,
  input  logic [3:0]       io_btn,
  output logic [31:0]      rdata,
  output logic [31:0]      ledr,
  output logic [31:0]      ledg,
  output logic [7:0][6:0]  hex,
  output logic [31:0]      lcd
);
  localparam int DW = $clog2(DMEM_WORDS);

  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] hex_lo, hex_hi, off, wd, word;
  logic [3:0]  be;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic        dmem_hit, sel_ledr, sel_ledg, sel_hexl, sel_hexh, sel_lcd, sel_sw, sel_btn;
  logic        unused_ok;

  assign off      = addr - DMEM_BASE;
  assign dmem_hit = off < 32'(DMEM_WORDS * 4);
  assign sel_ledr = addr[31:12] == LEDR_BASE[31:12];
  assign sel_ledg = addr[31:12] == LEDG_BASE[31:12];
  assign sel_hexl = addr[31:12] == HEXL_BASE[31:12];
  assign sel_hexh = addr[31:12] == HEXH_BASE[31:12];
  assign sel_lcd  = addr[31:12] == LCD_BASE[31:12];
  assign sel_sw   = addr[31:12] == SW_BASE[31:12];
  assign sel_btn  = addr[31:12] == BTN_BASE[31:12];

  // Replicate store data across lanes and pick the byte enables.
  always_comb begin
    be = 4'b1111;
    wd = wdata;
    case (funct3[1:0])
      2'b00: begin be = 4'b0001 << addr[1:0]; wd = {4{wdata[7:0]}}; end
      2'b01: begin be = addr[1] ? 4'b1100 : 4'b0011; wd = {2{wdata[15:0]}}; end
      default: ;
    endcase
  end

  // Data memory: byte-enabled write, contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && store && dmem_hit)
      for (int b = 0; b < 4; b++)
        if (be[b]) dmem[off[DW+1:2]][8*b +: 8] <= wd[8*b +: 8];
  end

  // Output registers; read-only and unmapped regions simply never match.
  always_ff @(posedge clk) begin
    if (rst) begin
      ledr <= '0; ledg <= '0; hex_lo <= '0; hex_hi <= '0; lcd <= '0;
    end else if (store) begin
      for (int b = 0; b < 4; b++) if (be[b]) begin
        if (sel_ledr) ledr[8*b +: 8]   <= wd[8*b +: 8];
        if (sel_ledg) ledg[8*b +: 8]   <= wd[8*b +: 8];
        if (sel_hexl) hex_lo[8*b +: 8] <= wd[8*b +: 8];
        if (sel_hexh) hex_hi[8*b +: 8] <= wd[8*b +: 8];
        if (sel_lcd)  lcd[8*b +: 8]    <= wd[8*b +: 8];
      end
    end
  end

  // Combinational load: region mux, lane select, then extension.
  always_comb begin
    word = '0;
    if (dmem_hit)      word = dmem[off[DW+1:2]];
    else if (sel_ledr) word = ledr;
    else if (sel_ledg) word = ledg;
    else if (sel_hexl) word = hex_lo;
    else if (sel_hexh) word = hex_hi;
    else if (sel_lcd)  word = lcd;
    else if (sel_sw)   word = io_sw;
    else if (sel_btn)  word = {28'b0, io_btn};
    bsel = 8'(word >> {addr[1:0], 3'b000});
    hsel = addr[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    rdata = {{24{bsel[7]}}, bsel};
      F3_BU:   rdata = {24'b0, bsel};
      F3_H:    rdata = {{16{hsel[15]}}, hsel};
      F3_HU:   rdata = {16'b0, hsel};
      default: rdata = word;
    endcase
  end

  for (genvar k = 0; k < 4; k++) begin : g_hex
    assign hex[k]   = hex_lo[8*k +: 7];
    assign hex[k+4] = hex_hi[8*k +: 7];
  end

  assign unused_ok = ^{hex_lo, hex_hi, off};

endmodule

// File: rtl/rv32i_singlecycle_core.sv
// Single-cycle RV32I core: fetch, decode, register file, ALU, branch and
// next-PC logic; memory and I/O live in rv32i_lsu.
module rv32i_singlecycle_core import rv32i_pkg::*; #(
  parameter int          IMEM_WORDS = 2048,
  parameter int          DMEM_WORDS = 2048,
  parameter logic [31:0] IMEM_INIT [IMEM_WORDS] = '{default: NOP_INSN}
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  output logic [31:0] o_pc_debug,
  output logic        o_insn_vld,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3,
  output logic [6:0]  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7,
  output logic [31:0] o_io_lcd
);
  localparam int IW = $clog2(IMEM_WORDS);

  logic [31:0] pc, npc, pc4, insn, imm, rs1v, rs2v, alu_a, alu_b, alu_y, ld_data, wb_data;
  logic [31:0] rf [32];
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        vld, reg_we, store, is_br, is_jal, is_jalr, b_imm, take;
  imm_e        imm_t;
  alu_a_e      a_sel;
  alu_op_e     alu_op;
  wb_e         wb;
  logic [7:0][6:0] hex;

  // Fetch; anything past the end of instruction memory reads as a NOP.
  always_comb insn = (pc < 32'(IMEM_WORDS * 4)) ? IMEM_INIT[pc[IW+1:2]] : NOP_INSN;

  assign rd  = insn[11:7];
  assign f3  = insn[14:12];
  assign rs1 = insn[19:15];
  assign rs2 = insn[24:20];
  assign imm = gen_imm(imm_t, insn[31:7]);

  // Control decode; unknown opcodes fall through as a NOP with vld low.
  always_comb begin
    vld = 1'b0; reg_we = 1'b0; store = 1'b0; is_br = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    b_imm = 1'b0; imm_t = IMM_I; a_sel = A_RS1; alu_op = ALU_ADD; wb = WB_ALU;
    case (insn[6:0])
      OP_LUI:    begin vld = 1'b1; reg_we = 1'b1; imm_t = IMM_U; a_sel = A_ZERO; b_imm = 1'b1; end
      OP_AUIPC:  begin vld = 1'b1; reg_we = 1'b1; imm_t = IMM_U; a_sel = A_PC; b_imm = 1'b1; end
      OP_JAL:    begin vld = 1'b1; reg_we = 1'b1; imm_t = IMM_J; is_jal = 1'b1; wb = WB_PC4; end
      OP_JALR:   begin vld = 1'b1; reg_we = 1'b1; b_imm = 1'b1; is_jalr = 1'b1; wb = WB_PC4; end
      OP_BRANCH: begin vld = 1'b1; imm_t = IMM_B; is_br = 1'b1; end
      OP_LOAD:   begin vld = 1'b1; reg_we = 1'b1; b_imm = 1'b1; wb = WB_MEM; end
      OP_STORE:  begin vld = 1'b1; store = 1'b1; b_imm = 1'b1; imm_t = IMM_S; end
      OP_IMM:    begin vld = 1'b1; reg_we = 1'b1; b_imm = 1'b1;
                       alu_op = alu_dec(f3, insn[30] && f3 == 3'd5); end
      OP_REG:    begin vld = 1'b1; reg_we = 1'b1; alu_op = alu_dec(f3, insn[30]); end
      OP_FENCE, OP_SYSTEM: vld = 1'b1;
      default: ;
    endcase
  end

  assign rs1v = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2v = (rs2 == 5'd0) ? '0 : rf[rs2];

  // ALU operand select and 32-bit wrap-around datapath.
  always_comb begin
    case (a_sel)
      A_PC:    alu_a = pc;
      A_ZERO:  alu_a = '0;
      default: alu_a = rs1v;
    endcase
    alu_b = b_imm ? imm : rs2v;
    case (alu_op)
      ALU_SUB:  alu_y = alu_a - alu_b;
      ALU_SLL:  alu_y = alu_a << alu_b[4:0];
      ALU_SLT:  alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'b0, alu_a < alu_b};
      ALU_XOR:  alu_y = alu_a ^ alu_b;
      ALU_SRL:  alu_y = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_y = $signed(alu_a) >>> alu_b[4:0];
      ALU_OR:   alu_y = alu_a | alu_b;
      ALU_AND:  alu_y = alu_a & alu_b;
      default:  alu_y = alu_a + alu_b;
    endcase
  end

  // Branch compare and next-PC selection.
  always_comb begin
    case (f3)
      F3_BEQ:  take = rs1v == rs2v;
      F3_BNE:  take = rs1v != rs2v;
      F3_BLT:  take = $signed(rs1v) < $signed(rs2v);
      F3_BGE:  take = $signed(rs1v) >= $signed(rs2v);
      F3_BLTU: take = rs1v < rs2v;
      F3_BGEU: take = rs1v >= rs2v;
      default: take = 1'b0;
    endcase
    pc4 = pc + 32'd4;
    if (is_jal || (is_br && take)) npc = pc + imm;
    else if (is_jalr)              npc = alu_y & ~32'd1;
    else                           npc = pc4;
    case (wb)
      WB_MEM:  wb_data = ld_data;
      WB_PC4:  wb_data = pc4;
      default: wb_data = alu_y;
    endcase
  end

  // PC register.
  always_ff @(posedge i_clk) begin
    if (i_rst) pc <= '0;
    else       pc <= npc;
  end

  // Register file write; x0 is never written.
  always_ff @(posedge i_clk) begin
    if (i_rst) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (reg_we && rd != 5'd0) rf[rd] <= wb_data;
  end

  rv32i_lsu #(.DMEM_WORDS(DMEM_WORDS)) u_lsu (
    .clk(i_clk), .rst(i_rst), .addr(alu_y), .wdata(rs2v), .funct3(f3), .store(store),
    .io_sw(i_io_sw), .io_btn(i_io_btn), .rdata(ld_data),
    .ledr(o_io_ledr), .ledg(o_io_ledg), .hex(hex), .lcd(o_io_lcd)
  );

  assign o_pc_debug = pc;
  assign o_insn_vld = vld && !i_rst;
  assign {o_io_hex7, o_io_hex6, o_io_hex5, o_io_hex4} = hex[7:4];
  assign {o_io_hex3, o_io_hex2, o_io_hex1, o_io_hex0} = hex[3:0];

endmodule

// File: tb/tb_rv32i_singlecycle_core.sv
// Directed program run on the core; register results are exposed by storing
// them to LEDR and checked against hand-computed values.
module tb_rv32i_singlecycle_core;
  localparam logic [31:0] PROG [2048] = '{
     0: 32'h00500093,  // addi x1,x0,5
     1: 32'hFFD00113,  // addi x2,x0,-3
     2: 32'h002081B3,  // add  x3,x1,x2
     3: 32'h40115233,  // sra  x4,x2,x1
     4: 32'h0020B2B3,  // sltu x5,x1,x2
     5: 32'h00700013,  // addi x0,x0,7
     6: 32'h10000537,  // lui  x10,0x10000
     7: 32'h00352023,  // sw x3,0(x10)
     8: 32'h00452023,  // sw x4,0(x10)
     9: 32'h00552023,  // sw x5,0(x10)
    10: 32'h00052023,  // sw x0,0(x10)
    11: 32'h10010337,  // lui x6,0x10010
    12: 32'h00032383,  // lw  x7,0(x6)
    13: 32'h00330403,  // lb  x8,3(x6)
    14: 32'h00035483,  // lhu x9,0(x6)
    15: 32'h00752023,  // sw x7,0(x10)
    16: 32'h008000EF,  // 0x40: jal x1,+8
    17: 32'h00052023,  // sw x0,0(x10) (skipped)
    18: 32'h00152023,  // sw x1,0(x10)
    19: 32'h00852023,  // sw x8,0(x10)
    20: 32'h00952023,  // sw x9,0(x10)
    21: 32'h100025B7,  // lui x11,0x10002
    22: 32'hFFF00693,  // addi x13,x0,-1
    23: 32'h10003737,  // lui x14,0x10003
    24: 32'h00D72023,  // sw x13,0(x14)
    25: 32'h03F00613,  // addi x12,x0,0x3f
    26: 32'h00C580A3,  // sb x12,1(x11)
    27: 32'h123457B7,  // lui x15,0x12345
    28: 32'h67878793,  // addi x15,x15,0x678
    29: 32'h00002837,  // lui x16,0x2
    30: 32'h00F82023,  // sw x15,0(x16)
    31: 32'h0000B8B7,  // lui x17,0xb
    32: 32'hBCD88893,  // addi x17,x17,-1075 -> 0xabcd
    33: 32'h01181123,  // sh x17,2(x16)
    34: 32'h00082903,  // lw x18,0(x16)
    35: 32'h01252023,  // sw x18,0(x10)
    36: 32'h000099B7,  // lui x19,0x9
    37: 32'h00F9A023,  // sw x15,0(x19)
    38: 32'h0009AA03,  // lw x20,0(x19)
    39: 32'h01452023,  // sw x20,0(x10)
    40: 32'h00000463,  // 0xA0: beq x0,x0,+8
    41: 32'h00F52023,  // sw x15,0(x10) (skipped)
    42: 32'h05500A93,  // addi x21,x0,0x55
    43: 32'h01552023,  // sw x21,0(x10)
    44: 32'h00001463,  // 0xB0: bne x0,x0,+8 (not taken)
    45: 32'h00152023,  // sw x1,0(x10)
    46: 32'h0C900B93,  // addi x23,x0,0xc9
    47: 32'h000B8C67,  // 0xBC: jalr x24,0(x23)
    48: 32'h00052023,
    49: 32'h00052023,
    50: 32'h01852023,  // 0xC8: sw x24,0(x10)
    51: 32'h0000007F,  // illegal opcode
    52: 32'h00000073,  // ecall
    53: 32'h10004CB7,  // lui x25,0x10004
    54: 32'h007CA023,  // sw x7,0(x25)
    55: 32'h000CAD03,  // lw x26,0(x25)
    56: 32'h01A52023,  // sw x26,0(x10)
    57: 32'h10001DB7,  // lui x27,0x10001
    58: 32'h005DA023,  // sw x5,0(x27)
    59: 32'h10011E37,  // lui x28,0x10011
    60: 32'h000E2E83,  // lw x29,0(x28)
    61: 32'h01D52023,  // sw x29,0(x10)
    62: 32'h0000006F,  // 0xF8: jal x0,0
    default: 32'h00000013
  };

  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic [31:0] i_io_sw = 32'hDEADBEEF;
  logic [3:0]  i_io_btn = 4'hA;
  logic [31:0] o_pc_debug, o_io_ledr, o_io_ledg, o_io_lcd;
  logic        o_insn_vld;
  logic [6:0]  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3;
  logic [6:0]  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7;
  int checks = 0, errors = 0;

  rv32i_singlecycle_core #(.IMEM_WORDS(2048), .DMEM_WORDS(2048), .IMEM_INIT(PROG)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_io_sw(i_io_sw), .i_io_btn(i_io_btn),
    .o_pc_debug(o_pc_debug), .o_insn_vld(o_insn_vld),
    .o_io_ledr(o_io_ledr), .o_io_ledg(o_io_ledg),
    .o_io_hex0(o_io_hex0), .o_io_hex1(o_io_hex1), .o_io_hex2(o_io_hex2), .o_io_hex3(o_io_hex3),
    .o_io_hex4(o_io_hex4), .o_io_hex5(o_io_hex5), .o_io_hex6(o_io_hex6), .o_io_hex7(o_io_hex7),
    .o_io_lcd(o_io_lcd)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_to(input logic [31:0] tgt);
    int n = 0;
    while (o_pc_debug !== tgt && n < 200) begin
      step();
      n++;
    end
    chk("run_to_pc", o_pc_debug, tgt);
  endtask

  initial begin
    step(); step();
    chk("rst_pc", o_pc_debug, 32'h0);
    chk("rst_vld", {31'b0, o_insn_vld}, 32'h0);
    chk("rst_ledr", o_io_ledr, 32'h0);
    chk("rst_ledg", o_io_ledg, 32'h0);
    chk("rst_lcd", o_io_lcd, 32'h0);
    chk("rst_hex", {o_io_hex7, o_io_hex6, o_io_hex5, o_io_hex4}, 32'h0);
    chk("rst_hex_lo", {o_io_hex3, o_io_hex2, o_io_hex1, o_io_hex0}, 32'h0);
    i_rst = 1'b0;
    #1;
    chk("pc0", o_pc_debug, 32'h0);
    chk("vld0", {31'b0, o_insn_vld}, 32'h1);
    step(); chk("pc4", o_pc_debug, 32'h4);
    step(); chk("pc8", o_pc_debug, 32'h8);

    run_to(32'h20); chk("add_x3", o_io_ledr, 32'h2);
    step();         chk("sra_x4", o_io_ledr, 32'hFFFFFFFF);
    step();         chk("sltu_x5", o_io_ledr, 32'h1);
    step();         chk("x0_zero", o_io_ledr, 32'h0);

    run_to(32'h40); chk("lw_sw_ledr", o_io_ledr, 32'hDEADBEEF);
    step();         chk("jal_pc", o_pc_debug, 32'h48);
    step();         chk("jal_link", o_io_ledr, 32'h44);
    step();         chk("lb_sext", o_io_ledr, 32'hFFFFFFDE);
    step();         chk("lhu_zext", o_io_ledr, 32'h0000BEEF);

    run_to(32'h68); chk("hex4_sw", {25'b0, o_io_hex4}, 32'h7F);
    chk("hex7_sw", {25'b0, o_io_hex7}, 32'h7F);
    step();         chk("hex1_sb", {25'b0, o_io_hex1}, 32'h3F);
    chk("hex0_keep", {25'b0, o_io_hex0}, 32'h0);
    chk("hex2_keep", {25'b0, o_io_hex2}, 32'h0);
    chk("hex3_keep", {25'b0, o_io_hex3}, 32'h0);
    chk("hex5_keep", {25'b0, o_io_hex5}, 32'h7F);

    run_to(32'h90); chk("dmem_sh_lw", o_io_ledr, 32'hABCD5678);
    run_to(32'hA0); chk("unmapped_ld", o_io_ledr, 32'h0);
    step();         chk("beq_taken", o_pc_debug, 32'hA8);
    step(); step(); chk("beq_path", o_io_ledr, 32'h55);
    chk("pc_b0", o_pc_debug, 32'hB0);
    step();         chk("bne_fall", o_pc_debug, 32'hB4);
    step();         chk("bne_exec", o_io_ledr, 32'h44);
    step(); step(); chk("jalr_odd", o_pc_debug, 32'hC8);
    step();         chk("jalr_link", o_io_ledr, 32'hC0);
    chk("illegal_vld", {31'b0, o_insn_vld}, 32'h0);
    step();         chk("illegal_pc", o_pc_debug, 32'hD0);
    chk("ecall_vld", {31'b0, o_insn_vld}, 32'h1);

    run_to(32'hDC); chk("lcd", o_io_lcd, 32'hDEADBEEF);
    run_to(32'hE4); chk("lcd_readback", o_io_ledr, 32'hDEADBEEF);
    run_to(32'hEC); chk("ledg", o_io_ledg, 32'h1);
    run_to(32'hF8); chk("buttons", o_io_ledr, 32'h0000000A);
    step();         chk("self_loop", o_pc_debug, 32'hF8);

    i_rst = 1'b1;
    step();
    chk("mid_rst_pc", o_pc_debug, 32'h0);
    chk("mid_rst_ledr", o_io_ledr, 32'h0);
    chk("mid_rst_ledg", o_io_ledg, 32'h0);
    chk("mid_rst_lcd", o_io_lcd, 32'h0);
    chk("mid_rst_hex4", {25'b0, o_io_hex4}, 32'h0);
    i_rst = 1'b0;
    step();
    chk("restart_pc", o_pc_debug, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
